// File: rtl/adc_serie_emulador.sv
// Serial ADC emulator: shifts a zero-padded sample out on datoADCSerie,
// driven by an externally supplied CS/sclk pair synchronized to clock.
module adc_serie_emulador #(
  parameter int LEADING_ZEROS = 4,
  parameter int DATA_BITS     = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 CS,
  input  logic                 sclk,
  input  logic [DATA_BITS-1:0] muestra,
  input  logic                 muestra_valid,
  output logic                 muestra_ready,
  output logic                 datoADCSerie,
  output logic                 frame_done,
  output logic                 underrun
);

  localparam int F  = LEADING_ZEROS + DATA_BITS;
  localparam int CW = $clog2(F + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  logic [2:0]             cs_q;
  logic [2:0]             sclk_q;
  logic [1:0]             vld_q;
  logic                   armed;
  logic [F-2:0]           rem;
  logic [CW-1:0]          cnt;
  logic                   hold_full;
  logic [DATA_BITS-1:0]   hold_reg;
  logic [DATA_BITS-1:0]   last;
  logic [DATA_BITS-1:0]   sel_sample;
  logic [F-1:0]           load_val;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_fall;
  logic                   load;
  logic                   xfer;

  assign cs_fall   = armed & cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

  assign load       = (state == IDLE) & cs_fall;
  assign xfer       = muestra_valid & ~hold_full;
  assign sel_sample = hold_full ? hold_reg : last;
  assign load_val   = F'(sel_sample);

  assign muestra_ready = ~hold_full;

  // Two-flop synchronizers plus an edge-detect stage for CS and sclk
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b111;
    end else begin
      cs_q   <= {cs_q[1:0], CS};
      sclk_q <= {sclk_q[1:0], sclk};
    end
  end

  // CS edges count only once a real high level has reached the sync stage
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 2'b00;
      armed <= 1'b0;
    end else begin
      vld_q <= {vld_q[0], 1'b1};
      armed <= armed | (vld_q[1] & cs_q[1]);
    end
  end

  // Holding register and last-sent sample bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
      last      <= '0;
    end else begin
      if (load) begin
        last <= sel_sample;
      end
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold_full <= 1'b1;
        hold_reg  <= muestra;
      end
    end
  end

  // Frame FSM with registered serial output and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      cnt          <= '0;
      datoADCSerie <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          datoADCSerie <= 1'b0;
          if (cs_fall) begin
            datoADCSerie <= load_val[F-1];
            rem          <= load_val[F-2:0];
            cnt          <= '0;
            underrun     <= ~hold_full;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            datoADCSerie <= 1'b0;
            state        <= IDLE;
          end else if (sclk_fall && !cs_q[1]) begin
            cnt <= cnt + 1'b1;
            rem <= {rem[F-3:0], 1'b0};
            if (cnt == CW'(F - 1)) begin
              frame_done   <= 1'b1;
              datoADCSerie <= 1'b0;
              state        <= DONE;
            end else begin
              datoADCSerie <= rem[F-2];
            end
          end
        end
        DONE: begin
          datoADCSerie <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: begin
          datoADCSerie <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serie_emulador.sv
// Bench for adc_serie_emulador: directed frames, scoreboard checked
// on each frame_done pulse by an independent monitor.
module tb_adc_serie_emulador;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        CS = 1'b1;
  logic        sclk = 1'b0;
  logic [11:0] muestra = '0;
  logic        muestra_valid = 1'b0;
  logic        muestra_ready;
  logic        datoADCSerie;
  logic        frame_done;
  logic        underrun;

  adc_serie_emulador dut (
    .clock         (clock),
    .reset         (reset),
    .CS            (CS),
    .sclk          (sclk),
    .muestra       (muestra),
    .muestra_valid (muestra_valid),
    .muestra_ready (muestra_ready),
    .datoADCSerie  (datoADCSerie),
    .frame_done    (frame_done),
    .underrun      (underrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] word;
    logic        und;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] rx_word = '0;
  logic        und_seen = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pop expected frame on every frame_done pulse
  always @(negedge clock) begin
    if (reset) begin
      und_seen = 1'b0;
    end else begin
      if (underrun) und_seen = 1'b1;
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected frame_done: word %h", rx_word);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame word", rx_word, mon_e.word);
          chk("frame underrun", und_seen, mon_e.und);
        end
        und_seen = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input logic [11:0] v);
    muestra       = v;
    muestra_valid = 1'b1;
    tick(1);
    muestra_valid = 1'b0;
    tick(1);
    chk("ready after transfer", muestra_ready, 0);
  endtask

  // CS falls; the load happens on the 3rd rising clock edge afterwards
  task automatic cs_start(input bit vol, input logic [11:0] v);
    rx_word = '0;
    CS      = 1'b0;
    tick(2);
    if (vol) begin
      chk("ready at load", muestra_ready, 1);
      muestra       = v;
      muestra_valid = 1'b1;
    end
    tick(1);
    muestra_valid = 1'b0;
    tick(3);
  endtask

  // Receiver samples on sclk rise, emulator shifts on sclk fall
  task automatic sclk_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rx_word = {rx_word[14:0], datoADCSerie};
      sclk    = 1'b1;
      tick(5);
      sclk    = 1'b0;
      tick(5);
    end
  endtask

  task automatic full_frame(input logic [15:0] w, input logic u,
                            input bit vol, input logic [11:0] v);
    exp_q.push_back('{w, u});
    cs_start(vol, v);
    sclk_cycles(16);
    tick(2);
    CS = 1'b1;
    tick(8);
  endtask

  logic und_hit;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset dato", datoADCSerie, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset underrun", underrun, 0);
    chk("reset ready", muestra_ready, 1);
    tick(4);

    // No preload: last sample is zero, underrun each time
    full_frame(16'h0000, 1'b1, 1'b0, 12'h000);
    full_frame(16'h0000, 1'b1, 1'b0, 12'h000);

    // Preloaded sample
    xfer(12'hA5C);
    full_frame(16'h0A5C, 1'b0, 1'b0, 12'h000);
    chk("ready after A5C frame", muestra_ready, 1);

    // Repeat of last sample when not reloaded
    xfer(12'hFFF);
    full_frame(16'h0FFF, 1'b0, 1'b0, 12'h000);
    full_frame(16'h0FFF, 1'b1, 1'b0, 12'h000);

    // Abort after 7 sclk falls
    xfer(12'h123);
    cs_start(1'b0, 12'h000);
    chk("ready after load", muestra_ready, 1);
    sclk_cycles(7);
    chk("abort bits", rx_word, 16'h0000);
    chk("dato bit8 before abort", datoADCSerie, 1);
    CS = 1'b1;
    tick(5);
    chk("dato after abort", datoADCSerie, 0);
    chk("ready after abort", muestra_ready, 1);
    tick(3);
    xfer(12'h456);
    full_frame(16'h0456, 1'b0, 1'b0, 12'h000);

    // Transfer on the exact load cycle
    full_frame(16'h0456, 1'b1, 1'b1, 12'h789);
    full_frame(16'h0789, 1'b0, 1'b0, 12'h000);

    // Reset mid-frame after 9 sclk falls, CS held low
    xfer(12'hABC);
    cs_start(1'b0, 12'h000);
    sclk_cycles(9);
    chk("bits before reset", rx_word, 16'h0015);
    reset = 1'b1;
    tick(2);
    chk("mid reset dato", datoADCSerie, 0);
    chk("mid reset ready", muestra_ready, 1);
    chk("mid reset frame_done", frame_done, 0);
    chk("mid reset underrun", underrun, 0);
    reset   = 1'b0;
    und_hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (underrun || datoADCSerie) und_hit = 1'b1;
    end
    chk("no load while CS low after reset", und_hit, 0);
    CS = 1'b1;
    tick(6);
    full_frame(16'h0000, 1'b1, 1'b0, 12'h000);
    xfer(12'hDEF);
    full_frame(16'h0DEF, 1'b0, 1'b0, 12'h000);

    tick(5);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_serie_emulador.md
ADC_SERIE_EMULADOR -- requirements
Module: adc_serie_emulador

Interface
REQ-001 Parameter LEADING_ZEROS, default 4: number of zero bits sent before data in each frame.
REQ-002 Parameter DATA_BITS, default 12: sample width, sent MSB first; frame length F = LEADING_ZEROS + DATA_BITS (16 by default).
REQ-003 Port clock  input  1: single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port CS  input  1: active-low chip select from the ADC receiver; asynchronous to clock.
REQ-006 Port sclk  input  1: serial clock from the ADC receiver; asynchronous to clock; period >= 8 clock cycles.
REQ-007 Port muestra  input  DATA_BITS: parallel sample to be transmitted.
REQ-008 Port muestra_valid  input  1: muestra is valid this cycle.
REQ-009 Port muestra_ready  output  1: holding register empty; a transfer occurs when valid and ready are both high.
REQ-010 Port datoADCSerie  output  1: serial data line to the receiver.
REQ-011 Port frame_done  output  1: one-cycle pulse when a full frame has been shifted.
REQ-012 Port underrun  output  1: one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-013 CS and sclk SHALL each pass through a 2-flop synchronizer, followed by a third register for edge detection; a pin edge is acted on 3 clock cycles after it occurs.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE: datoADCSerie = 0; a synchronized CS falling edge loads the shift register with {LEADING_ZEROS zeros, sample} and clears the bit counter, then moves to SHIFT.
REQ-016 Sample selection at load: the holding register if it is full, which empties it; otherwise the last sent sample, with a one-cycle underrun pulse.
REQ-017 SHIFT: datoADCSerie SHALL equal the shift-register MSB, so the first leading zero is driven from the load cycle.
REQ-018 SHIFT: each synchronized sclk falling edge with CS low shifts the register left by one (zero fill) and increments the counter.
REQ-019 On the F-th sclk falling edge: pulse frame_done, drive datoADCSerie = 0 and move to DONE; sclk edges in DONE are ignored.
REQ-020 A synchronized CS rising edge in SHIFT SHALL abort the frame and return to IDLE: no frame_done, the sample stays consumed, datoADCSerie = 0 next cycle.
REQ-021 DONE: a synchronized CS rising edge returns to IDLE.
REQ-022 sclk edges while in IDLE SHALL be ignored.
REQ-023 muestra_ready = holding register empty; a transfer writes muestra into the holding register and sets it full.
REQ-024 Load and transfer in the same cycle (register empty): the load uses the last sample and pulses underrun; the transferred value fills the holding register for the next frame.
REQ-025 Last-sample register SHALL update to the value loaded at every frame start.
REQ-026 Data bit k (MSB = k=1) SHALL be valid on datoADCSerie from the (LEADING_ZEROS+k-1)-th synchronized sclk falling edge, stable through the following sclk rising edge.

Reset
REQ-027 Reset SHALL force: state IDLE, datoADCSerie = 0, frame_done = 0, underrun = 0, holding register empty (muestra_ready = 1 on the cycle after reset deasserts), last sample = 0, bit counter = 0, synchronizer flops = CS 1 / sclk 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, no edge detection on CS until it is seen high, then low again.

Verification
REQ-029 Preload muestra = 12'hA5C; CS low; 16 sclk cycles (period 10 clocks) -> sampled on sclk rising edges the bits read 0000_1010_0101_1100, one frame_done pulse, underrun = 0, muestra_ready = 1 after load.
REQ-030 No preload after reset; one frame -> underrun pulse at load, serial word 16'h0000; a second frame with none loaded repeats the previous value.
REQ-031 Preload 12'hFFF, run a frame; do not reload; run again -> both frames 16'h0FFF, second frame underrun = 1.
REQ-032 CS rises after 7 sclk falling edges -> return to IDLE, no frame_done, datoADCSerie = 0; the next frame uses the next held sample.
REQ-033 muestra_valid asserted on the exact load cycle with the register empty -> current frame uses the last sample with underrun; the next frame sends the new value.
REQ-034 Reset pulse after 9 sclk edges -> all outputs at reset values, muestra_ready = 1; the next full CS cycle yields a correct frame.
